// File: rtl/draw_map_pkg.sv
// Shared map types, map geometry and tile colours for the snake renderer.
package draw_map_pkg;

  localparam int unsigned MAP_WIDTH  = 40;
  localparam int unsigned MAP_HEIGHT = 30;

  // Tile encoding; codes 4..7 are not assigned to any tile type.
  typedef logic [2:0] tile_t;
  localparam tile_t TILE_EMPTY  = 3'd0;
  localparam tile_t TILE_SNAKE1 = 3'd1;
  localparam tile_t TILE_SNAKE2 = 3'd2;
  localparam tile_t TILE_POINT  = 3'd3;

  typedef struct packed {
    logic [5:0] head_x;
    logic [5:0] head_y;
  } snake_s;

  // tiles[row][column]
  typedef struct packed {
    tile_t [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] tiles;
    snake_s                                snake1;
    snake_s                                snake2;
  } map_s;

  // Tile colours, 4:4:4 RGB.
  localparam logic [11:0] EMPTY_RGB       = 12'h000;
  localparam logic [11:0] GRID_RGB        = 12'h222;
  localparam logic [11:0] SNAKE1_RGB      = 12'h0F0;
  localparam logic [11:0] SNAKE1_HEAD_RGB = 12'h8F8;
  localparam logic [11:0] SNAKE2_RGB      = 12'h00F;
  localparam logic [11:0] SNAKE2_HEAD_RGB = 12'h88F;
  localparam logic [11:0] POINT_RGB       = 12'hF00;
  localparam logic [11:0] UNKNOWN_RGB     = 12'h888;

endpackage

// File: rtl/draw_map_if.sv
// VGA timing bus with colour; master drives, slave receives.
interface draw_map_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_map_delay.sv
// Fixed-length shift register used to keep the timing bus aligned with colour.
module draw_map_delay #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DEL = 3
) (
  input  logic             clk_75,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [CLK_DEL];

  // Shift din through CLK_DEL registers, clearing all of them on reset.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[CLK_DEL-1];

endmodule

// File: rtl/draw_map.sv
// Paints the per-frame map snapshot as tile blocks onto the VGA timing bus.
module draw_map
  import draw_map_pkg::*;
#(
  parameter int unsigned TILE_SIZE  = 16,
  parameter int unsigned MAP_X0     = 0,
  parameter int unsigned MAP_Y0     = 0,
  parameter int unsigned BLINK_BITS = 5
) (
  input  logic       clk_75,
  input  logic       rst,
  input  map_s       map_in,
  draw_map_if.slave  vga_src,
  draw_map_if.master vga_dst
);

  localparam int unsigned SHIFT = $clog2(TILE_SIZE);
  localparam int unsigned TX_W  = $clog2(MAP_WIDTH);
  localparam int unsigned TY_W  = $clog2(MAP_HEIGHT);
  localparam int unsigned BUS_W = 26;

  // Snapshot and frame counter
  tile_t [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] snap_tiles;
  snake_s                                snap_head1;
  snake_s                                snap_head2;
  logic                                  vblnk_prev;
  logic [BLINK_BITS-1:0]                 frame_cnt;

  // Capture the map on each vblank rising edge so a frame never shows two map states.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      frame_cnt  <= '0;
      snap_tiles <= '0;
      snap_head1 <= '0;
      snap_head2 <= '0;
    end else begin
      vblnk_prev <= vga_src.vblnk;
      if (vga_src.vblnk && !vblnk_prev) begin
        snap_tiles <= map_in.tiles;
        snap_head1 <= map_in.snake1;
        snap_head2 <= map_in.snake2;
        frame_cnt  <= frame_cnt + BLINK_BITS'(1);
      end
    end
  end

  // Stage 1: pixel to tile coordinates
  logic [11:0] dx_ext, dy_ext;
  logic [10:0] tx_full, ty_full;
  logic        in_map;

  // The extra top bit of the subtraction flags pixels left of / above the map origin.
  always_comb begin
    dx_ext  = {1'b0, vga_src.hcount} - 12'(MAP_X0);
    dy_ext  = {1'b0, vga_src.vcount} - 12'(MAP_Y0);
    tx_full = dx_ext[10:0] >> SHIFT;
    ty_full = dy_ext[10:0] >> SHIFT;
    in_map  = !dx_ext[11] && !dy_ext[11] &&
              (tx_full < 11'(MAP_WIDTH)) && (ty_full < 11'(MAP_HEIGHT));
  end

  logic [5:0]       s1_tx, s1_ty;
  logic [SHIFT-1:0] s1_px, s1_py;
  logic             s1_in_map, s1_hblnk, s1_vblnk;
  logic [11:0]      s1_rgb;

  // Register tile coordinates; out-of-map pixels index tile 0 to stay in range.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      s1_tx     <= '0;
      s1_ty     <= '0;
      s1_px     <= '0;
      s1_py     <= '0;
      s1_in_map <= 1'b0;
      s1_hblnk  <= 1'b0;
      s1_vblnk  <= 1'b0;
      s1_rgb    <= '0;
    end else begin
      s1_tx     <= in_map ? tx_full[5:0] : 6'd0;
      s1_ty     <= in_map ? ty_full[5:0] : 6'd0;
      s1_px     <= dx_ext[SHIFT-1:0];
      s1_py     <= dy_ext[SHIFT-1:0];
      s1_in_map <= in_map;
      s1_hblnk  <= vga_src.hblnk;
      s1_vblnk  <= vga_src.vblnk;
      s1_rgb    <= vga_src.rgb;
    end
  end

  // Stage 2: tile lookup and head match
  tile_t            s2_tile;
  logic             s2_head1, s2_head2;
  logic [SHIFT-1:0] s2_px, s2_py;
  logic             s2_in_map, s2_hblnk, s2_vblnk;
  logic [11:0]      s2_rgb;

  // Read the snapshot tile under the pixel and flag whether it holds a snake head.
  always_ff @(posedge clk_75) begin
    if (rst) begin
      s2_tile   <= TILE_EMPTY;
      s2_head1  <= 1'b0;
      s2_head2  <= 1'b0;
      s2_px     <= '0;
      s2_py     <= '0;
      s2_in_map <= 1'b0;
      s2_hblnk  <= 1'b0;
      s2_vblnk  <= 1'b0;
      s2_rgb    <= '0;
    end else begin
      s2_tile   <= s1_in_map ? snap_tiles[s1_ty[TY_W-1:0]][s1_tx[TX_W-1:0]] : TILE_EMPTY;
      s2_head1  <= (s1_tx == snap_head1.head_x) && (s1_ty == snap_head1.head_y);
      s2_head2  <= (s1_tx == snap_head2.head_x) && (s1_ty == snap_head2.head_y);
      s2_px     <= s1_px;
      s2_py     <= s1_py;
      s2_in_map <= s1_in_map;
      s2_hblnk  <= s1_hblnk;
      s2_vblnk  <= s1_vblnk;
      s2_rgb    <= s1_rgb;
    end
  end

  // Stage 3: colour select
  logic [11:0] rgb_next, empty_rgb, rgb;
  logic        point_area;

  // Pick the pixel colour by priority: blanking, off-map, then tile type.
  always_comb begin
    point_area = (s2_px >= SHIFT'(2)) && (s2_px <= SHIFT'(TILE_SIZE - 3)) &&
                 (s2_py >= SHIFT'(2)) && (s2_py <= SHIFT'(TILE_SIZE - 3));
    empty_rgb  = ((s2_px == '0) || (s2_py == '0)) ? GRID_RGB : EMPTY_RGB;
    rgb_next   = UNKNOWN_RGB;
    if (s2_hblnk || s2_vblnk) begin
      rgb_next = 12'h000;
    end else if (!s2_in_map) begin
      rgb_next = s2_rgb;
    end else begin
      case (s2_tile)
        TILE_SNAKE1: rgb_next = s2_head1 ? SNAKE1_HEAD_RGB : SNAKE1_RGB;
        TILE_SNAKE2: rgb_next = s2_head2 ? SNAKE2_HEAD_RGB : SNAKE2_RGB;
        TILE_POINT:  rgb_next = (!frame_cnt[BLINK_BITS-1] && point_area) ? POINT_RGB : empty_rgb;
        TILE_EMPTY:  rgb_next = empty_rgb;
        default:     rgb_next = UNKNOWN_RGB;
      endcase
    end
  end

  // Register the final colour.
  always_ff @(posedge clk_75) begin
    if (rst) rgb <= '0;
    else     rgb <= rgb_next;
  end

  logic [BUS_W-1:0] bus_in, bus_out;

  assign bus_in = {vga_src.hcount, vga_src.vcount, vga_src.hsync, vga_src.vsync,
                   vga_src.hblnk, vga_src.vblnk};

  draw_map_delay #(
    .WIDTH   (BUS_W),
    .CLK_DEL (3)
  ) u_delay (
    .clk_75 (clk_75),
    .rst    (rst),
    .din    (bus_in),
    .dout   (bus_out)
  );

  assign {vga_dst.hcount, vga_dst.vcount, vga_dst.hsync, vga_dst.vsync,
          vga_dst.hblnk, vga_dst.vblnk} = bus_out;
  assign vga_dst.rgb = rgb;

endmodule
